// File: rtl/scfifo_valid_tracked_model.sv
// Single-clock FIFO model that stores a shadow valid bit with every data word.
// Depth may be any value >= 2 (pointers wrap explicitly at lpm_numwords-1).
// Normal mode registers the read word one clock after an accepted read.
// Showahead mode presents the head entry continuously.
// Occupancy flags are registered and always agree with usedw in the same cycle.
// overflow and underflow are sticky and are cleared only by aclr_n.
//
// Handshake: a write is taken on any rising edge where wrreq=1 and full=0.
// A read is taken on any rising edge where rdreq=1 and empty=0.
// Both flags are sampled from pre-edge state. A request that is refused is
// dropped, not held pending, and it sets the matching sticky error flag.
module scfifo_valid_tracked_model #(
  parameter int lpm_width         = 8,
  parameter int lpm_numwords      = 16,
  parameter int lpm_widthu        = 4,
  parameter int lpm_showahead     = 0,
  parameter int almost_full_value = 12
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  input  logic [lpm_width-1:0]  data,
  input  logic                  data_valid,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [lpm_width-1:0]  q,
  output logic                  q_valid,
  output logic                  q_valid_q,
  output logic [lpm_widthu:0]   usedw,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [lpm_widthu-1:0] last_ptr  = lpm_widthu'(lpm_numwords - 1);
  localparam logic [lpm_widthu:0]   depth_cnt = (lpm_widthu + 1)'(lpm_numwords);
  localparam logic [lpm_widthu:0]   af_cnt    = (lpm_widthu + 1)'(almost_full_value);

  // Storage: data words are never reset, shadow valid bits are.
  logic [lpm_width-1:0]    mem [lpm_numwords];
  logic [lpm_numwords-1:0] stored_valid;

  logic [lpm_widthu-1:0] wr_ptr;
  logic [lpm_widthu-1:0] rd_ptr;
  logic [lpm_widthu-1:0] wr_ptr_nxt;
  logic [lpm_widthu-1:0] rd_ptr_nxt;
  logic [lpm_widthu:0]   usedw_nxt;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  head_valid;

  // Acceptance decisions use the registered flags, i.e. pre-edge state.
  always_comb begin
    wr_acc     = wrreq & ~full;
    rd_acc     = rdreq & ~empty;
    head_valid = stored_valid[rd_ptr];
  end

  // Pointer increment with explicit wrap so non-power-of-two depths work.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (wr_acc) wr_ptr_nxt = (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
    if (rd_acc) rd_ptr_nxt = (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
  end

  // Next occupancy: +1 for an accepted write, -1 for an accepted read.
  always_comb begin
    usedw_nxt = usedw;
    if (wr_acc && !rd_acc) usedw_nxt = usedw + 1'b1;
    if (rd_acc && !wr_acc) usedw_nxt = usedw - 1'b1;
  end

  // Data array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data;
  end

  // Shadow valid bits are stored per entry and cleared by reset.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      stored_valid <= '0;
    end else if (wr_acc) begin
      stored_valid[wr_ptr] <= data_valid;
    end
  end

  // Pointers, occupancy and flags, all derived from the same next count.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      usedw       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      usedw       <= usedw_nxt;
      empty       <= (usedw_nxt == '0);
      full        <= (usedw_nxt == depth_cnt);
      almost_full <= (usedw_nxt >= af_cnt);
    end
  end

  // Sticky error flags: a dropped write or a dropped read.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wrreq && full)  overflow  <= 1'b1;
      if (rdreq && empty) underflow <= 1'b1;
    end
  end

  generate
    if (lpm_showahead != 0) begin : g_showahead
      // Head entry is visible at all times; q_valid is masked while empty.
      always_comb begin
        q       = mem[rd_ptr];
        q_valid = ~empty & head_valid;
      end
    end else begin : g_normal
      // Registered read port: q updates only on an accepted read, while
      // q_valid is a single-cycle pulse for a valid-tagged word.
      always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
          q       <= '0;
          q_valid <= 1'b0;
        end else begin
          if (rd_acc) q <= mem[rd_ptr];
          q_valid <= rd_acc & head_valid;
        end
      end
    end
  endgenerate

  // One-cycle delayed copy of q_valid for downstream pipeline alignment.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      q_valid_q <= 1'b0;
    end else begin
      q_valid_q <= q_valid;
    end
  end

endmodule

// File: tb/tb_scfifo_valid_tracked_model.sv
// Bench for scfifo_valid_tracked_model.
// Three configurations share the same input stream:
//   inst 0: depth 16, normal read mode
//   inst 1: depth 5, normal read mode
//   inst 2: depth 16, showahead read mode
// The reference model keeps one queue of {valid, data} per instance.
module tb_scfifo_valid_tracked_model;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic aclr_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] data = '0;
  logic       data_valid = 1'b0;
  logic       wrreq = 1'b0;
  logic       rdreq = 1'b0;

  logic [7:0] q_o   [3];
  logic       qv_o  [3];
  logic       qvq_o [3];
  logic       emp_o [3];
  logic       full_o[3];
  logic       af_o  [3];
  logic       ovf_o [3];
  logic       unf_o [3];
  logic [4:0] usedw0;
  logic [3:0] usedw1;
  logic [4:0] usedw2;

  scfifo_valid_tracked_model #(.lpm_width(8), .lpm_numwords(16), .lpm_widthu(4),
    .lpm_showahead(0), .almost_full_value(12)) u_n16 (
    .clk(clk), .aclr_n(aclr_n), .data(data), .data_valid(data_valid),
    .wrreq(wrreq), .rdreq(rdreq), .q(q_o[0]), .q_valid(qv_o[0]),
    .q_valid_q(qvq_o[0]), .usedw(usedw0), .empty(emp_o[0]), .full(full_o[0]),
    .almost_full(af_o[0]), .overflow(ovf_o[0]), .underflow(unf_o[0]));

  scfifo_valid_tracked_model #(.lpm_width(8), .lpm_numwords(5), .lpm_widthu(3),
    .lpm_showahead(0), .almost_full_value(4)) u_n5 (
    .clk(clk), .aclr_n(aclr_n), .data(data), .data_valid(data_valid),
    .wrreq(wrreq), .rdreq(rdreq), .q(q_o[1]), .q_valid(qv_o[1]),
    .q_valid_q(qvq_o[1]), .usedw(usedw1), .empty(emp_o[1]), .full(full_o[1]),
    .almost_full(af_o[1]), .overflow(ovf_o[1]), .underflow(unf_o[1]));

  scfifo_valid_tracked_model #(.lpm_width(8), .lpm_numwords(16), .lpm_widthu(4),
    .lpm_showahead(1), .almost_full_value(12)) u_s16 (
    .clk(clk), .aclr_n(aclr_n), .data(data), .data_valid(data_valid),
    .wrreq(wrreq), .rdreq(rdreq), .q(q_o[2]), .q_valid(qv_o[2]),
    .q_valid_q(qvq_o[2]), .usedw(usedw2), .empty(emp_o[2]), .full(full_o[2]),
    .almost_full(af_o[2]), .overflow(ovf_o[2]), .underflow(unf_o[2]));

  // ---------------- reference model ----------------
  int         depth [3] = '{16, 5, 16};
  int         afv   [3] = '{12, 4, 12};
  int         sa    [3] = '{0, 0, 1};
  logic [8:0] mq    [3][$];   // {valid, data}, front = oldest
  logic [7:0] m_q   [3];
  logic       m_qv  [3];
  logic       m_qvq [3];
  logic       m_ovf [3];
  logic       m_unf [3];

  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      m_q[i] = '0; m_qv[i] = 1'b0; m_qvq[i] = 1'b0;
      m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
    end
  endtask

  // One rising edge with the given request inputs.
  task automatic model_edge(input logic w, input logic r, input logic [7:0] d, input logic v);
    int   cnt;
    logic wa, ra, qv_before;
    logic [8:0] head;
    for (int i = 0; i < 3; i++) begin
      cnt = mq[i].size();
      wa = w && (cnt != depth[i]);
      ra = r && (cnt != 0);
      if (w && cnt == depth[i]) m_ovf[i] = 1'b1;
      if (r && cnt == 0)        m_unf[i] = 1'b1;
      qv_before = m_qv[i];
      head = (cnt != 0) ? mq[i][0] : 9'h0;
      if (ra) void'(mq[i].pop_front());
      if (wa) mq[i].push_back({v, d});
      if (sa[i] == 0) begin
        if (ra) m_q[i] = head[7:0];
        m_qv[i] = ra && head[8];
      end else begin
        m_qv[i] = (mq[i].size() != 0) && mq[i][0][8];
      end
      m_qvq[i] = qv_before;
    end
  endtask

  // ---------------- scoreboard checks ----------------
  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic check_all();
    int cnt;
    logic [4:0] uw;
    for (int i = 0; i < 3; i++) begin
      cnt = mq[i].size();
      uw = (i == 0) ? usedw0 : (i == 1) ? {1'b0, usedw1} : usedw2;
      chk("usedw", i, 32'(uw), 32'(cnt));
      chk("empty", i, 32'(emp_o[i]), 32'(cnt == 0));
      chk("full", i, 32'(full_o[i]), 32'(cnt == depth[i]));
      chk("almost_full", i, 32'(af_o[i]), 32'(cnt >= afv[i]));
      chk("overflow", i, 32'(ovf_o[i]), 32'(m_ovf[i]));
      chk("underflow", i, 32'(unf_o[i]), 32'(m_unf[i]));
      chk("q_valid", i, 32'(qv_o[i]), 32'(m_qv[i]));
      chk("q_valid_q", i, 32'(qvq_o[i]), 32'(m_qvq[i]));
      if (sa[i] == 0) chk("q", i, 32'(q_o[i]), 32'(m_q[i]));
      else if (cnt != 0) chk("q_head", i, 32'(q_o[i]), 32'(mq[i][0][7:0]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic v);
    wrreq = w; rdreq = r; data = d; data_valid = v;
    @(posedge clk);
    model_edge(w, r, d, v);
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset asserted between edges, checked before any clock edge.
  task automatic do_reset();
    wrreq = 1'b0; rdreq = 1'b0;
    aclr_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    aclr_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Two writes with differing valid tags, then two reads.
    step(1, 0, 8'hA5, 1);
    step(1, 0, 8'h3C, 0);
    step(0, 1, 8'h00, 0);
    chk("rd0_data", 0, 32'(q_o[0]), 32'h0A5);
    chk("rd0_valid", 0, 32'(qv_o[0]), 32'h1);
    step(0, 1, 8'h00, 0);
    chk("rd1_data", 0, 32'(q_o[0]), 32'h03C);
    chk("rd1_valid", 0, 32'(qv_o[0]), 32'h0);
    chk("rd1_valid_q", 0, 32'(qvq_o[0]), 32'h1);
    step(0, 0, 8'h00, 0);

    // Fill to full, overflow, then simultaneous read and write while full.
    for (int k = 0; k < 16; k++) step(1, 0, 8'(8'h40 + k), 1'(k % 2 == 0));
    chk("full16", 0, 32'(full_o[0]), 32'h1);
    step(1, 0, 8'hEE, 1);
    step(1, 1, 8'hEF, 1);
    chk("full_rw_usedw", 0, 32'(usedw0), 32'd15);
    chk("full_rw_data", 0, 32'(q_o[0]), 32'h040);
    chk("overflow_sticky", 0, 32'(ovf_o[0]), 32'h1);

    // Drain past empty (underflow), then simultaneous read and write when empty.
    for (int k = 0; k < 18; k++) step(0, 1, 8'h00, 0);
    step(1, 1, 8'h77, 1);
    chk("empty_rw_usedw", 0, 32'(usedw0), 32'd1);
    step(0, 1, 8'h00, 0);
    chk("empty_rw_data", 0, 32'(q_o[0]), 32'h077);

    // Continuous streaming: depth-5 pointers wrap several times.
    do_reset();
    step(1, 0, 8'h80, 1);
    for (int k = 1; k < 12; k++) step(1, 1, 8'(8'h80 + k), 1'(k % 3 != 0));
    step(0, 1, 8'h00, 0);
    chk("wrap_last", 1, 32'(q_o[1]), 32'h08B);

    // Showahead: a write into an empty FIFO is visible the next cycle.
    do_reset();
    step(1, 0, 8'h11, 1);
    chk("sa_data", 2, 32'(q_o[2]), 32'h011);
    chk("sa_valid", 2, 32'(qv_o[2]), 32'h1);
    step(0, 1, 8'h00, 0);
    chk("sa_empty", 2, 32'(emp_o[2]), 32'h1);
    chk("sa_valid_gone", 2, 32'(qv_o[2]), 32'h0);

    // Reset mid-stream with seven entries, then a read of the empty FIFO.
    do_reset();
    for (int k = 0; k < 7; k++) step(1, 0, 8'(8'hC0 + k), 1);
    chk("pre_reset_usedw", 0, 32'(usedw0), 32'd7);
    do_reset();
    step(0, 1, 8'h00, 0);
    chk("post_reset_underflow", 0, 32'(unf_o[0]), 32'h1);

    // Randomized traffic, write-heavy then read-heavy, with one reset inside.
    for (int k = 0; k < 600; k++) begin
      int pw, pr;
      if (k == 300) do_reset();
      pw = ((k / 100) % 2 == 0) ? 75 : 35;
      pr = ((k / 100) % 2 == 0) ? 35 : 75;
      step(1'($urandom_range(99, 0) < pw), 1'($urandom_range(99, 0) < pr),
           8'($urandom), 1'($urandom_range(1, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scfifo_valid_tracked_model.md
Name: scfifo_valid_tracked_model

Overview:
- Parametrised single-clock FIFO behavioural model that carries a per-entry shadow valid bit alongside the data word.
- Used in verification and instrumentation builds in place of a vendor FIFO, so downstream valid-propagation checks know whether each output word was written with valid data.
- Generalises the earlier 1-bit dual-clock valid model in three ways: configurable data width, configurable depth (non-power-of-two allowed), and normal or showahead read mode.
- Adds occupancy, almost-full and sticky error flags.

Parameters:
- lpm_width, 8: data word width in bits.
- lpm_numwords, 16: FIFO depth in entries, >= 2; need not be a power of two.
- lpm_widthu, 4: pointer width, = ceil(log2(lpm_numwords)).
- lpm_showahead, 0: 0 = normal mode (q valid one cycle after rdreq); 1 = showahead mode (q presents the head entry).
- almost_full_value, 12: almost_full asserts when usedw >= this value.

Ports:
- clk  input  1  sole clock, rising edge.
- aclr_n  input  1  asynchronous active-low reset.
- data  input  lpm_width  write data.
- data_valid  input  1  shadow valid bit stored with data.
- wrreq  input  1  write request.
- rdreq  input  1  read request (normal mode) / head acknowledge (showahead mode).
- q  output  lpm_width  read data.
- q_valid  output  1  shadow valid bit of the word on q, qualified by the read.
- q_valid_q  output  1  q_valid delayed one clk.
- usedw  output  lpm_widthu+1  current occupancy, 0..lpm_numwords.
- empty  output  1  usedw == 0.
- full  output  1  usedw == lpm_numwords.
- almost_full  output  1  usedw >= almost_full_value.
- overflow  output  1  sticky: a write was dropped.
- underflow  output  1  sticky: a read was dropped.

Behaviour:
- Reset (aclr_n low, asynchronous):
  - Write and read pointers = 0; usedw = 0; empty = 1; full = 0; almost_full = 0.
  - q = 0; q_valid = 0; q_valid_q = 0; overflow = 0; underflow = 0.
  - All stored shadow valid bits cleared to 0. Data array contents are not cleared.
  - Reset mid-operation discards all contents; the first clk after deassertion behaves as an empty FIFO.
- Write acceptance: wr_acc = wrreq & ~full.
  - On wr_acc, {data_valid, data} are stored at wr_ptr and wr_ptr advances.
  - wrreq while full: write dropped, overflow set.
- Read acceptance: rd_acc = rdreq & ~empty.
  - On rd_acc, rd_ptr advances.
  - rdreq while empty: read dropped, underflow set, no state change.
- Flags are evaluated on pre-edge state. Simultaneous wrreq and rdreq:
  - When full: the read is accepted and the write is dropped (overflow set); usedw goes to lpm_numwords-1.
  - When empty: the write is accepted and the read is dropped (underflow set); usedw goes to 1.
  - Otherwise both are accepted and usedw is unchanged.
- Pointer wrap: a pointer at lpm_numwords-1 advances to 0. This applies to non-power-of-two depths too.
- usedw update: usedw += wr_acc - rd_acc each edge. empty, full and almost_full are registered and consistent with usedw in the same cycle.
- Normal mode (lpm_showahead=0):
  - On rd_acc, q <= mem[rd_ptr] at the edge, so latency is 1 clk.
  - q holds its value when there is no rd_acc.
  - q_valid <= rd_acc & stored_valid[rd_ptr]. q_valid is therefore 1 only for exactly one cycle after an accepted read of a valid-tagged entry, and 0 otherwise, including after dropped reads.
- Showahead mode (lpm_showahead=1):
  - q = mem[rd_ptr] continuously.
  - q_valid = ~empty & stored_valid[rd_ptr].
  - rdreq acknowledges the head; the next entry appears the cycle after rd_acc.
  - A write into an empty FIFO appears on q the cycle after wr_acc.
- q_valid_q <= q_valid every clk.
- overflow and underflow are cleared only by reset.

Test Plan:
- Reset, lpm_numwords=16, normal mode. Write 0xA5 with data_valid=1, then 0x3C with data_valid=0. Read twice -> q=0xA5 with q_valid=1, then q=0x3C with q_valid=0, each 1 clk after its rdreq; q_valid_q follows q_valid one clk later; usedw 2→0 and empty returns to 1.
- Write 16 entries -> full=1, usedw=16, almost_full=1 from usedw=12. A 17th wrreq -> dropped and overflow=1. Then wrreq+rdreq together while full -> usedw=15, overflow stays 1, the read returns entry 0.
- rdreq while empty -> underflow=1, q unchanged, q_valid=0. wrreq+rdreq together while empty -> usedw=1, data retained.
- lpm_numwords=5: write and read 12 words continuously -> pointers wrap 4→0, data order preserved, usedw never exceeds 5.
- lpm_showahead=1: write 0x11 (valid=1) into empty FIFO -> q=0x11 and q_valid=1 one clk after the write. Assert rdreq -> q_valid=0 and empty=1 the following cycle.
- Assert aclr_n low mid-stream with usedw=7 -> usedw=0, empty=1, q_valid=0 and both sticky flags=0 immediately. A following read -> underflow=1 and no stale valid returned.
